// File: rtl/swap_engine.sv
// Register-file swap/copy engine: exchanges or copies two entries of a DEPTH x WIDTH
// register file on a start/done handshake, with a host read/write port usable while idle.
module swap_engine #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             mode_i,
    input  logic [AW-1:0]    addr_a_i,
    input  logic [AW-1:0]    addr_b_i,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [15:0]      op_count_o
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        WRITE_A,
        WRITE_B,
        COPY,
        DONE
    } state_t;

    // DEPTH need not be a power of two, so the address space can exceed the file.
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    function automatic logic in_range(input logic [AW-1:0] addr);
        return {1'b0, addr} < DEPTH_W;
    endfunction

    state_t             state_q, state_d;
    logic [AW-1:0]      la_q, la_d;
    logic [AW-1:0]      lb_q, lb_d;
    logic [WIDTH-1:0]   tmp_q, tmp_d;
    logic               err_q, err_d;
    logic [15:0]        op_count_q, op_count_d;
    logic [WIDTH-1:0]   mem_q [DEPTH];

    logic               mem_we;
    logic [AW-1:0]      mem_waddr;
    logic [WIDTH-1:0]   mem_wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            la_q       <= '0;
            lb_q       <= '0;
            tmp_q      <= '0;
            err_q      <= 1'b0;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            la_q       <= la_d;
            lb_q       <= lb_d;
            tmp_q      <= tmp_d;
            err_q      <= err_d;
            op_count_q <= op_count_d;
        end
    end

    // Host writes and engine writes share one port; they never collide since host writes are IDLE-only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        state_d    = state_q;
        la_d       = la_q;
        lb_d       = lb_q;
        tmp_d      = tmp_q;
        err_d      = 1'b0;
        op_count_d = op_count_q;
        mem_we     = 1'b0;
        mem_waddr  = '0;
        mem_wdata  = '0;

        case (state_q)
            IDLE: begin
                if (wr_en_i && in_range(wr_addr_i)) begin
                    mem_we    = 1'b1;
                    mem_waddr = wr_addr_i;
                    mem_wdata = wr_data_i;
                end
                if (start_i) begin
                    if (!in_range(addr_a_i) || !in_range(addr_b_i)) begin
                        err_d = 1'b1;
                    end else begin
                        la_d = addr_a_i;
                        lb_d = addr_b_i;
                        if (addr_a_i == addr_b_i) begin
                            state_d = DONE;
                        end else if (mode_i) begin
                            state_d = COPY;
                        end else begin
                            state_d = LOAD_A;
                        end
                    end
                end
            end
            LOAD_A: begin
                tmp_d   = mem_q[la_q];
                state_d = WRITE_A;
            end
            WRITE_A: begin
                mem_we    = 1'b1;
                mem_waddr = la_q;
                mem_wdata = mem_q[lb_q];
                state_d   = WRITE_B;
            end
            WRITE_B: begin
                mem_we    = 1'b1;
                mem_waddr = lb_q;
                mem_wdata = tmp_q;
                state_d   = DONE;
            end
            COPY: begin
                mem_we    = 1'b1;
                mem_waddr = lb_q;
                mem_wdata = mem_q[la_q];
                state_d   = DONE;
            end
            DONE: begin
                op_count_d = op_count_q + 16'd1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rd_data_o  = in_range(rd_addr_i) ? mem_q[rd_addr_i] : '0;
    assign busy_o     = (state_q != IDLE);
    assign done_o     = (state_q == DONE);
    assign err_o      = err_q;
    assign op_count_o = op_count_q;

endmodule
